// File: rtl/ga_pkg.sv
// GA coprocessor interface types, opcode/funct constants and issue-FSM states.
// Pure declarations: no latency, no flow control.
package ga_pkg;

    localparam logic [6:0]  GA_OPCODE    = 7'b0001011;
    localparam int unsigned GA_FUNCT_NUM = 8;

    typedef enum logic [4:0] {
        GA_ADD   = 5'd0,
        GA_SUB   = 5'd1,
        GA_MUL   = 5'd2,
        GA_WEDGE = 5'd3,
        GA_DOT   = 5'd4,
        GA_REV   = 5'd5,
        GA_DUAL  = 5'd6,
        GA_NORM  = 5'd7
    } ga_funct_e;

    typedef enum logic [1:0] {
        GA_IDLE,
        GA_ISSUE,
        GA_WAIT,
        GA_WB
    } ga_issue_state_e;

    typedef struct packed {
        logic        valid;
        ga_funct_e   funct;
        logic [31:0] operand_a;
        logic [31:0] operand_b;
        logic [4:0]  ga_reg_a;
        logic [4:0]  ga_reg_b;
        logic [4:0]  rd_addr;
        logic        use_ga_regs;
        logic        we;
    } ga_req_t;

    typedef struct packed {
        logic        valid;
        logic        busy;
        logic        error;
        logic        overflow;
        logic        underflow;
        logic [31:0] result;
    } ga_resp_t;

endpackage

// File: rtl/ga_issue_unit.sv
// Decodes custom-0 GA instructions, stalls ID, issues one coprocessor request and retires it.
// Request waits in ISSUE while resp.busy; status pulses and RF writeback are registered (1 cycle after the deciding event).
module ga_issue_unit
    import ga_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 64,
    parameter logic        GAEnable      = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs1_rdata_i,
    input  logic [31:0] rs2_rdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        illegal_o,
    output logic        error_o,
    output logic        timeout_o,
    output logic        done_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_wdata_o,
    output ga_req_t     ga_req_o,
    input  ga_resp_t    ga_resp_i
);

    localparam int unsigned     CntW    = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    ga_issue_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    ga_req_t         req_q, req_d;
    logic            illegal_q, illegal_d;
    logic            error_q, error_d;
    logic            timeout_q, timeout_d;
    logic            done_q, done_d;
    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_addr_q, wb_addr_d;
    logic [31:0]     wb_wdata_q, wb_wdata_d;

    logic is_ga;
    logic accept;
    logic legal;
    logic needs_wb;
    logic unused_bits;

    assign is_ga    = (instr_i[6:0] == GA_OPCODE);
    assign accept   = instr_valid_i & is_ga & ~flush_i;
    assign legal    = GAEnable && ({27'b0, instr_i[29:25]} < GA_FUNCT_NUM);
    // Only integer-destination ops with a real rd need the RF write cycle.
    assign needs_wb = ~req_q.we & (req_q.rd_addr != 5'd0);

    assign unused_bits = ^{ga_resp_i.overflow, ga_resp_i.underflow, instr_i[31:30], instr_i[14]};

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        req_d            = req_q;
        illegal_d        = 1'b0;
        error_d          = 1'b0;
        timeout_d        = 1'b0;
        done_d           = 1'b0;
        wb_we_d          = 1'b0;
        wb_addr_d        = 5'd0;
        wb_wdata_d       = 32'd0;
        ga_req_o         = req_q;
        ga_req_o.valid   = 1'b0;

        case (state_q)
            GA_IDLE: begin
                if (accept) begin
                    if (!legal) begin
                        illegal_d = 1'b1;
                    end else begin
                        req_d.valid       = 1'b0;
                        req_d.funct       = ga_funct_e'(instr_i[29:25]);
                        req_d.operand_a   = rs1_rdata_i;
                        req_d.operand_b   = rs2_rdata_i;
                        req_d.ga_reg_a    = instr_i[19:15];
                        req_d.ga_reg_b    = instr_i[24:20];
                        req_d.rd_addr     = instr_i[11:7];
                        req_d.use_ga_regs = instr_i[12];
                        req_d.we          = instr_i[13];
                        state_d           = GA_ISSUE;
                    end
                end
            end
            GA_ISSUE: begin
                if (flush_i) begin
                    state_d = GA_IDLE;
                end else if (!ga_resp_i.busy) begin
                    ga_req_o.valid = 1'b1;
                    cnt_d          = '0;
                    state_d        = GA_WAIT;
                end
            end
            GA_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (ga_resp_i.valid) begin
                    cnt_d   = '0;
                    state_d = GA_IDLE;
                    if (ga_resp_i.error) begin
                        error_d = 1'b1;
                    end else if (needs_wb) begin
                        state_d    = GA_WB;
                        wb_we_d    = 1'b1;
                        wb_addr_d  = req_q.rd_addr;
                        wb_wdata_d = ga_resp_i.result;
                        done_d     = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (cnt_q == CntLast) begin
                    cnt_d     = '0;
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = GA_IDLE;
                end
            end
            GA_WB: begin
                state_d = GA_IDLE;
            end
            default: begin
                state_d = GA_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= GA_IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            illegal_q  <= 1'b0;
            error_q    <= 1'b0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_addr_q  <= 5'd0;
            wb_wdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            illegal_q  <= illegal_d;
            error_q    <= error_d;
            timeout_q  <= timeout_d;
            done_q     <= done_d;
            wb_we_q    <= wb_we_d;
            wb_addr_q  <= wb_addr_d;
            wb_wdata_q <= wb_wdata_d;
        end
    end

    assign stall_o    = (state_q != GA_IDLE) | accept;
    assign illegal_o  = illegal_q;
    assign error_o    = error_q;
    assign timeout_o  = timeout_q;
    assign done_o     = done_q;
    assign wb_we_o    = wb_we_q;
    assign wb_addr_o  = wb_addr_q;
    assign wb_wdata_o = wb_wdata_q;

endmodule

// File: tb/tb_ga_issue_unit.sv
// Scoreboarded bench for ga_issue_unit: stimulus queues cycle-stamped expected events and stall-run lengths,
// a monitor compares every active output cycle and every completed stall run against them.
module tb_ga_issue_unit;
    import ga_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_valid_i;
    logic [31:0] instr_i;
    logic [31:0] rs1_rdata_i;
    logic [31:0] rs2_rdata_i;
    logic        flush_i;
    logic        stall_o;
    logic        illegal_o;
    logic        error_o;
    logic        timeout_o;
    logic        done_o;
    logic        wb_we_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_wdata_o;
    ga_req_t     ga_req_o;
    ga_resp_t    ga_resp_i;

    always #5 clk_i = ~clk_i;

    ga_issue_unit #(.TimeoutCycles(8), .GAEnable(1'b1)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .instr_valid_i (instr_valid_i),
        .instr_i       (instr_i),
        .rs1_rdata_i   (rs1_rdata_i),
        .rs2_rdata_i   (rs2_rdata_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .illegal_o     (illegal_o),
        .error_o       (error_o),
        .timeout_o     (timeout_o),
        .done_o        (done_o),
        .wb_we_o       (wb_we_o),
        .wb_addr_o     (wb_addr_o),
        .wb_wdata_o    (wb_wdata_o),
        .ga_req_o      (ga_req_o),
        .ga_resp_i     (ga_resp_i)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic        req_vld;
        logic [4:0]  funct;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  reg_a;
        logic [4:0]  reg_b;
        logic [4:0]  rd;
        logic        use_r;
        logic        we;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        done;
        logic        err;
        logic        tmo;
        logic        ill;
    } obs_t;

    obs_t        evq[$];
    int          stallq[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] cyc      = 32'd0;
    logic        rst_seen = 1'b0;
    bit          stim_done = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 32'd1;
    always @(posedge clk_i) rst_seen <= rst_i;

    function automatic obs_t mk_req(input logic [31:0] c, input logic [4:0] f,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] ra, input logic [4:0] rb,
                                    input logic [4:0] rd, input logic use_r, input logic we);
        obs_t o;
        o         = '0;
        o.cyc     = c;
        o.req_vld = 1'b1;
        o.funct   = f;
        o.op_a    = a;
        o.op_b    = b;
        o.reg_a   = ra;
        o.reg_b   = rb;
        o.rd      = rd;
        o.use_r   = use_r;
        o.we      = we;
        return o;
    endfunction

    function automatic obs_t mk_out(input logic [31:0] c, input logic wbwe, input logic [4:0] addr,
                                    input logic [31:0] data, input logic done, input logic err,
                                    input logic tmo, input logic ill);
        obs_t o;
        o         = '0;
        o.cyc     = c;
        o.wb_we   = wbwe;
        o.wb_addr = addr;
        o.wb_data = data;
        o.done    = done;
        o.err     = err;
        o.tmo     = tmo;
        o.ill     = ill;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic issue(input logic [4:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic use_r, input logic we,
                         input logic [31:0] a, input logic [31:0] b);
        instr_i       = {2'b00, f, rs2, rs1, 1'b0, we, use_r, rd, GA_OPCODE};
        instr_valid_i = 1'b1;
        rs1_rdata_i   = a;
        rs2_rdata_i   = b;
        tick();
        instr_valid_i = 1'b0;
        instr_i       = 32'd0;
    endtask

    task automatic respond(input logic err, input logic [31:0] res);
        ga_resp_i.valid  = 1'b1;
        ga_resp_i.error  = err;
        ga_resp_i.result = res;
        tick();
        ga_resp_i.valid  = 1'b0;
        ga_resp_i.error  = 1'b0;
        ga_resp_i.result = 32'd0;
    endtask

    // Stimulus: c0 is the cycle the instruction is presented; offsets are hand-derived DUT timing.
    initial begin
        logic [31:0] c0;
        rst_i         = 1'b1;
        instr_valid_i = 1'b0;
        instr_i       = 32'd0;
        rs1_rdata_i   = 32'd0;
        rs2_rdata_i   = 32'd0;
        flush_i       = 1'b0;
        ga_resp_i     = '0;
        idle(3);
        rst_i = 1'b0;
        idle(2);

        // ADD rd=5: req next cycle, resp 3 cycles after req, WB with result 7.
        c0 = cyc;
        evq.push_back(mk_req(c0 + 1, GA_ADD, 32'd3, 32'd4, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0));
        evq.push_back(mk_out(c0 + 5, 1'b1, 5'd5, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0));
        stallq.push_back(6);  // decode cycle + ISSUE + 3x WAIT + WB
        issue(GA_ADD, 5'd5, 5'd3, 5'd4, 1'b0, 1'b0, 32'd3, 32'd4);
        idle(3);
        respond(1'b0, 32'd7);
        idle(3);

        // busy held 4 cycles in ISSUE; we=1 so retire without RF write.
        ga_resp_i.busy = 1'b1;
        c0 = cyc;
        evq.push_back(mk_req(c0 + 5, GA_SUB, 32'd10, 32'd4, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1));
        evq.push_back(mk_out(c0 + 8, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        stallq.push_back(8);
        issue(GA_SUB, 5'd6, 5'd1, 5'd2, 1'b1, 1'b1, 32'd10, 32'd4);
        idle(4);
        ga_resp_i.busy = 1'b0;
        idle(2);
        respond(1'b0, 32'd6);
        idle(3);

        // No response: timeout 8 cycles after WAIT entry, late resp ignored.
        c0 = cyc;
        evq.push_back(mk_req(c0 + 1, GA_MUL, 32'd2, 32'd3, 5'd8, 5'd9, 5'd7, 1'b0, 1'b0));
        evq.push_back(mk_out(c0 + 10, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0));
        stallq.push_back(10);
        issue(GA_MUL, 5'd7, 5'd8, 5'd9, 1'b0, 1'b0, 32'd2, 32'd3);
        idle(10);
        respond(1'b0, 32'hdead_beef);
        idle(3);

        // funct=31 is illegal.
        c0 = cyc;
        evq.push_back(mk_out(c0 + 1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        stallq.push_back(1);
        issue(5'd31, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(3);

        // Flush in ISSUE while busy: no request.
        ga_resp_i.busy = 1'b1;
        stallq.push_back(2);
        issue(GA_DOT, 5'd4, 5'd1, 5'd1, 1'b0, 1'b0, 32'd5, 32'd5);
        flush_i = 1'b1;
        tick();
        flush_i        = 1'b0;
        ga_resp_i.busy = 1'b0;
        idle(3);

        // Flush in WAIT is ignored.
        c0 = cyc;
        evq.push_back(mk_req(c0 + 1, GA_ADD, 32'd100, 32'd23, 5'd10, 5'd11, 5'd9, 1'b0, 1'b0));
        evq.push_back(mk_out(c0 + 4, 1'b1, 5'd9, 32'd123, 1'b1, 1'b0, 1'b0, 1'b0));
        stallq.push_back(5);
        issue(GA_ADD, 5'd9, 5'd10, 5'd11, 1'b0, 1'b0, 32'd100, 32'd23);
        tick();
        flush_i = 1'b1;
        tick();
        respond(1'b0, 32'd123);
        flush_i = 1'b0;
        idle(3);

        // Coprocessor error response.
        c0 = cyc;
        evq.push_back(mk_req(c0 + 1, GA_WEDGE, 32'd1, 32'd2, 5'd12, 5'd13, 5'd2, 1'b0, 1'b0));
        evq.push_back(mk_out(c0 + 4, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        stallq.push_back(4);
        issue(GA_WEDGE, 5'd2, 5'd12, 5'd13, 1'b0, 1'b0, 32'd1, 32'd2);
        idle(2);
        respond(1'b1, 32'h55);
        idle(3);

        // Reset during WAIT, later resp.valid ignored.
        c0 = cyc;
        evq.push_back(mk_req(c0 + 1, GA_REV, 32'd7, 32'd8, 5'd14, 5'd15, 5'd3, 1'b0, 1'b0));
        stallq.push_back(4);
        issue(GA_REV, 5'd3, 5'd14, 5'd15, 1'b0, 1'b0, 32'd7, 32'd8);
        idle(2);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        respond(1'b0, 32'h99);
        idle(3);

        // Minimum-latency response right after reset recovery, rd=31.
        c0 = cyc;
        evq.push_back(mk_req(c0 + 1, GA_ADD, 32'd40, 32'd2, 5'd16, 5'd17, 5'd31, 1'b0, 1'b0));
        evq.push_back(mk_out(c0 + 3, 1'b1, 5'd31, 32'd42, 1'b1, 1'b0, 1'b0, 1'b0));
        stallq.push_back(4);
        issue(GA_ADD, 5'd31, 5'd16, 5'd17, 1'b0, 1'b0, 32'd40, 32'd2);
        tick();
        respond(1'b0, 32'd42);
        idle(4);

        stim_done = 1'b1;
    end

    // Monitor: sole owner of checks/failures.
    initial begin
        int   run;
        int   exp_run;
        obs_t act;
        obs_t exp;
        run = 0;
        while (!stim_done) begin
            @(negedge clk_i);
            if (rst_seen) begin
                checks++;
                if (ga_req_o !== '0 || wb_we_o !== 1'b0 || wb_addr_o !== 5'd0 || wb_wdata_o !== 32'd0 ||
                    done_o !== 1'b0 || error_o !== 1'b0 || timeout_o !== 1'b0 || illegal_o !== 1'b0 ||
                    stall_o !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_state cyc=%0d: req=%h wb_we=%b done=%b err=%b tmo=%b ill=%b stall=%b, required all zero",
                             cyc, ga_req_o, wb_we_o, done_o, error_o, timeout_o, illegal_o, stall_o);
                end
            end else if (ga_req_o.valid === 1'b1 || wb_we_o === 1'b1 || done_o === 1'b1 ||
                         error_o === 1'b1 || timeout_o === 1'b1 || illegal_o === 1'b1) begin
                act       = '0;
                act.cyc   = cyc;
                if (ga_req_o.valid === 1'b1) begin
                    act.req_vld = 1'b1;
                    act.funct   = ga_req_o.funct;
                    act.op_a    = ga_req_o.operand_a;
                    act.op_b    = ga_req_o.operand_b;
                    act.reg_a   = ga_req_o.ga_reg_a;
                    act.reg_b   = ga_req_o.ga_reg_b;
                    act.rd      = ga_req_o.rd_addr;
                    act.use_r   = ga_req_o.use_ga_regs;
                    act.we      = ga_req_o.we;
                end
                act.wb_we = wb_we_o;
                if (wb_we_o === 1'b1) begin
                    act.wb_addr = wb_addr_o;
                    act.wb_data = wb_wdata_o;
                end
                act.done = done_o;
                act.err  = error_o;
                act.tmo  = timeout_o;
                act.ill  = illegal_o;
                checks++;
                if (evq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event cyc=%0d: got %h, required no activity", cyc, act);
                end else begin
                    exp = evq.pop_front();
                    if (act !== exp) begin
                        failures++;
                        $display("FAIL event cyc=%0d: got %h, required %h", cyc, act, exp);
                    end
                end
            end

            if (stall_o === 1'b1) begin
                run++;
            end else if (run > 0) begin
                checks++;
                if (stallq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_stall cyc=%0d: got run of %0d, required none", cyc, run);
                end else begin
                    exp_run = stallq.pop_front();
                    if (run != exp_run) begin
                        failures++;
                        $display("FAIL stall_len cyc=%0d: got %0d cycles, required %0d", cyc, run, exp_run);
                    end
                end
                run = 0;
            end
        end

        checks++;
        if (evq.size() != 0) begin
            failures++;
            $display("FAIL missing_events: got %0d outstanding, required 0", evq.size());
        end
        checks++;
        if (stallq.size() != 0) begin
            failures++;
            $display("FAIL missing_stalls: got %0d outstanding, required 0", stallq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
